// File: rtl/qpsk_timing_pkg.sv
// Shared Q1.15 constants and helpers for the timing-recovery NCO.
// Covers the default W step, the clamp limits and the fractional-interval ceiling.
package qpsk_timing_pkg;

    localparam int unsigned Q_W    = 16;
    localparam int unsigned Q_FRAC = 15;

    localparam logic [Q_W-1:0] ONE_Q15      = 16'h8000;
    localparam logic [Q_W-1:0] UK_MAX       = 16'h7FFF;
    localparam logic [Q_W-1:0] W0_DEF       = 16'h4000;
    localparam logic [Q_W-1:0] W_MIN_DEF    = 16'h3800;
    localparam logic [Q_W-1:0] W_MAX_DEF    = 16'h4800;
    localparam logic [Q_W-1:0] ETA_INIT_DEF = 16'h0000;

    typedef logic [Q_W-1:0] q15_t;

    // W0 + wk is formed at 17 bits so that a large correction saturates instead of wrapping.
    function automatic q15_t clamp_step(
        input q15_t                  w0,
        input logic signed [Q_W-1:0] wk,
        input q15_t                  w_min,
        input q15_t                  w_max
    );
        logic signed [Q_W:0] sum;
        q15_t                res;
        sum = $signed({1'b0, w0}) + $signed({wk[Q_W-1], wk});
        if (sum < $signed({1'b0, w_min})) begin
            res = w_min;
        end else if (sum > $signed({1'b0, w_max})) begin
            res = w_max;
        end else begin
            res = sum[Q_W-1:0];
        end
        return res;
    endfunction

    // eta/W with W taken as 0.5, i.e. 2*eta, saturated to just below 1.0.
    function automatic q15_t uk_approx(input q15_t eta_v);
        logic [Q_W:0] dbl;
        q15_t         res;
        dbl = {eta_v, 1'b0};
        if (dbl > {1'b0, UK_MAX}) begin
            res = UK_MAX;
        end else begin
            res = dbl[Q_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/nco_timing_ctrl_uk_divider.sv
// Combinational restoring divider: quotient = min((dividend << 15) / divisor, 0x7FFF).
// The 15 quotient bits are produced by an unrolled chain of compare/subtract stages.
module uk_divider
    import qpsk_timing_pkg::*;
(
    input  logic [Q_W-1:0] dividend_i,
    input  logic [Q_W-1:0] divisor_i,
    output logic [Q_W-1:0] quotient_o
);

    localparam int unsigned N = Q_FRAC;

    logic [N-1:0][Q_W:0] rem;
    logic [N-1:0]        q_bits;
    logic                saturate;

    // A dividend at or above the divisor means a ratio >= 1.0; a zero divisor lands here too.
    assign saturate = (dividend_i >= divisor_i);
    assign rem[0]   = {1'b0, dividend_i};

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_stage
            logic [Q_W+1:0] shifted;
            logic           take;

            assign shifted           = {rem[gi], 1'b0};
            assign take              = (shifted >= {2'b00, divisor_i});
            assign q_bits[N-1-gi]    = take;

            if (gi < N - 1) begin : g_rem
                logic [Q_W:0] trial;
                assign trial       = take ? (shifted[Q_W:0] - {1'b0, divisor_i}) : shifted[Q_W:0];
                assign rem[gi + 1] = trial;
            end
        end
    endgenerate

    assign quotient_o = saturate ? UK_MAX : {1'b0, q_bits};

endmodule

// File: rtl/nco_timing_ctrl.sv
// Timing-recovery NCO: decrements a modulo-1 register by W each clock and emits strobe/uk on underflow.
// Build option NCO_EXACT_DIV_EN replaces the 2*eta interval estimate with an exact eta/W divide.
module nco_timing_ctrl
    import qpsk_timing_pkg::*;
#(
    parameter logic [Q_W-1:0] W0       = W0_DEF,
    parameter logic [Q_W-1:0] W_MIN    = W_MIN_DEF,
    parameter logic [Q_W-1:0] W_MAX    = W_MAX_DEF,
    parameter logic [Q_W-1:0] ETA_INIT = ETA_INIT_DEF
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wk_vld,
    input  logic signed [Q_W-1:0] wk,
    output logic                  strobe,
    output logic [Q_W-1:0]        uk,
    output logic [Q_W-1:0]        eta
);

    logic [Q_W-1:0]        eta_q, eta_d;
    logic [Q_W-1:0]        w_q, w_d;
    logic [Q_W-1:0]        uk_q, uk_d;
    logic                  strobe_q, strobe_d;
    logic [Q_W-1:0]        uk_calc;
    logic signed [Q_W:0]   diff;
    logic                  underflow;

    assign diff      = $signed({1'b0, eta_q}) - $signed({1'b0, w_q});
    assign underflow = diff[Q_W];

    // uk is always formed from the pre-decrement eta and the W in force this cycle.
`ifdef NCO_EXACT_DIV_EN
    uk_divider u_uk_divider (
        .dividend_i (eta_q),
        .divisor_i  (w_q),
        .quotient_o (uk_calc)
    );
`else
    assign uk_calc = uk_approx(eta_q);
`endif

    always_comb begin
        w_d      = w_q;
        eta_d    = diff[Q_W-1:0];
        strobe_d = 1'b0;
        uk_d     = uk_q;

        if (wk_vld) begin
            w_d = clamp_step(W0, wk, W_MIN, W_MAX);
        end

        // Exactly zero remainder is not an underflow; only a negative difference wraps.
        if (underflow) begin
            eta_d    = diff[Q_W-1:0] + ONE_Q15;
            strobe_d = 1'b1;
            uk_d     = uk_calc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eta_q    <= ETA_INIT;
            w_q      <= W0;
            strobe_q <= 1'b0;
            uk_q     <= '0;
        end else begin
            eta_q    <= eta_d;
            w_q      <= w_d;
            strobe_q <= strobe_d;
            uk_q     <= uk_d;
        end
    end

    assign strobe = strobe_q;
    assign uk     = uk_q;
    assign eta    = eta_q;

endmodule

// File: tb/tb_nco_timing_ctrl.sv
// Directed bench: two NCOs (ETA_INIT 0 and 0x1000) stepped edge by edge against hand-computed tables.
// Covers clamping, step change, simultaneous wk/underflow, 1-clock spacing, uk saturation and mid-run reset.
module tb_nco_timing_ctrl;

`ifdef NCO_EXACT_DIV_EN
`define UKV(a, e) (e)
`else
`define UKV(a, e) (a)
`endif

    logic        clk;
    logic        rst_n;
    logic        wk_vld_a, wk_vld_b;
    logic [15:0] wk_a, wk_b;
    logic        strobe_a, strobe_b;
    logic [15:0] uk_a, uk_b, eta_a, eta_b;

    int n_checks = 0;
    int n_errors = 0;

    nco_timing_ctrl u_dut_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .wk_vld (wk_vld_a),
        .wk     (wk_a),
        .strobe (strobe_a),
        .uk     (uk_a),
        .eta    (eta_a)
    );

    nco_timing_ctrl #(.ETA_INIT(16'h1000)) u_dut_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .wk_vld (wk_vld_b),
        .wk     (wk_b),
        .strobe (strobe_b),
        .uk     (uk_b),
        .eta    (eta_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected state after each clock edge following reset release (index = edge - 1).
    localparam logic EXP_S_A [21] = '{1,0,1,0,1,0,1,1,0,1,0,1,0,1,0,1,0,1,0,1,1};
    localparam logic [15:0] EXP_ETA_A [21] = '{
        16'h4000, 16'h0000, 16'h4000, 16'h0000, 16'h4000, 16'h0000, 16'h3800, 16'h7000,
        16'h2800, 16'h6000, 16'h1800, 16'h6000, 16'h2800, 16'h7000, 16'h2800, 16'h6000,
        16'h1800, 16'h5000, 16'h0800, 16'h4000, 16'h7800};
    localparam logic [15:0] EXP_UK_A [21] = '{
        16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
        `UKV(16'h7000, 16'h638E), `UKV(16'h7000, 16'h638E),
        `UKV(16'h5000, 16'h471C), `UKV(16'h5000, 16'h471C),
        `UKV(16'h3000, 16'h36DB), `UKV(16'h3000, 16'h36DB),
        `UKV(16'h5000, 16'h5B6D), `UKV(16'h5000, 16'h5B6D),
        `UKV(16'h5000, 16'h471C), `UKV(16'h5000, 16'h471C),
        `UKV(16'h3000, 16'h2AAA), `UKV(16'h3000, 16'h2AAA),
        `UKV(16'h1000, 16'h0E38), `UKV(16'h7FFF, 16'h71C7)};

    localparam logic EXP_S_B [21] = '{1,0,1,0,1,0,1,0,1,0,1,0,0,1,0,1,0,1,0,0,1};
    localparam logic [15:0] EXP_ETA_B [21] = '{
        16'h5000, 16'h1000, 16'h5000, 16'h1000, 16'h5000, 16'h1000, 16'h5800, 16'h2000,
        16'h6800, 16'h3000, 16'h7800, 16'h4000, 16'h0800, 16'h5000, 16'h1800, 16'h6000,
        16'h2800, 16'h7000, 16'h3800, 16'h0000, 16'h4800};
    localparam logic [15:0] EXP_UK_B [21] = '{
        16'h2000, 16'h2000, 16'h2000, 16'h2000, 16'h2000, 16'h2000,
        `UKV(16'h2000, 16'h2492), `UKV(16'h2000, 16'h2492),
        `UKV(16'h4000, 16'h4924), `UKV(16'h4000, 16'h4924),
        `UKV(16'h6000, 16'h6DB6), `UKV(16'h6000, 16'h6DB6), `UKV(16'h6000, 16'h6DB6),
        `UKV(16'h1000, 16'h1249), `UKV(16'h1000, 16'h1249),
        `UKV(16'h3000, 16'h36DB), `UKV(16'h3000, 16'h36DB),
        `UKV(16'h5000, 16'h5B6D), `UKV(16'h5000, 16'h5B6D), `UKV(16'h5000, 16'h5B6D),
        16'h0000};

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_edge(input string pfx, input int idx);
        check_val($sformatf("%s_a_strobe", pfx), {15'd0, strobe_a}, {15'd0, EXP_S_A[idx]});
        check_val($sformatf("%s_a_eta", pfx), eta_a, EXP_ETA_A[idx]);
        check_val($sformatf("%s_a_uk", pfx), uk_a, EXP_UK_A[idx]);
        check_val($sformatf("%s_b_strobe", pfx), {15'd0, strobe_b}, {15'd0, EXP_S_B[idx]});
        check_val($sformatf("%s_b_eta", pfx), eta_b, EXP_ETA_B[idx]);
        check_val($sformatf("%s_b_uk", pfx), uk_b, EXP_UK_B[idx]);
    endtask

    task automatic check_reset_state(input string pfx);
        check_val($sformatf("%s_a_strobe", pfx), {15'd0, strobe_a}, 16'h0000);
        check_val($sformatf("%s_a_eta", pfx), eta_a, 16'h0000);
        check_val($sformatf("%s_a_uk", pfx), uk_a, 16'h0000);
        check_val($sformatf("%s_b_strobe", pfx), {15'd0, strobe_b}, 16'h0000);
        check_val($sformatf("%s_b_eta", pfx), eta_b, 16'h1000);
        check_val($sformatf("%s_b_uk", pfx), uk_b, 16'h0000);
    endtask

    task automatic show(input string pfx);
        $display("%s: A s=%0d eta=%h uk=%h | B s=%0d eta=%h uk=%h",
                 pfx, strobe_a, eta_a, uk_a, strobe_b, eta_b, uk_b);
    endtask

    initial begin
        rst_n    = 1'b0;
        wk_vld_a = 1'b0;
        wk_a     = 16'h0000;
        wk_vld_b = 1'b0;
        wk_b     = 16'h0000;

        repeat (2) @(posedge clk);
        #1;
        show("reset");
        check_reset_state("reset");

        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 21; k++) begin
            @(posedge clk);
            #1;
            show($sformatf("edge %0d", k + 1));
            check_edge($sformatf("e%0d", k + 1), k);

            wk_vld_a = 1'b0;
            wk_vld_b = 1'b0;
            case (k + 1)
                5: begin
                    wk_vld_a = 1'b1; wk_a = 16'h2000;
                    wk_vld_b = 1'b1; wk_b = 16'hF800;
                end
                10: begin
                    wk_vld_a = 1'b1; wk_a = 16'hE000;
                end
                13: begin
                    wk_vld_a = 1'b1; wk_a = 16'h7FFF;
                end
                default: ;
            endcase
        end

        // Asynchronous reset between edges, with wk pulses that must be ignored.
        #2;
        rst_n    = 1'b0;
        wk_vld_a = 1'b1; wk_a = 16'h7FFF;
        wk_vld_b = 1'b1; wk_b = 16'h7FFF;
        #1;
        show("async reset");
        check_reset_state("arst");

        repeat (2) @(posedge clk);
        #1;
        show("held reset");
        check_reset_state("hold");

        @(negedge clk);
        wk_vld_a = 1'b0;
        wk_vld_b = 1'b0;
        rst_n    = 1'b1;

        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            show($sformatf("rewalk %0d", k + 1));
            check_edge($sformatf("rw%0d", k + 1), k);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
